// File: rtl/wb_defs_pkg.sv
// Shared Wishbone cycle-type / burst-type codes plus the line-fill master's
// state encoding and response record.
package wb_defs_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  index;
        logic        last;
        logic        err;
    } rsp_t;

    // Word position inside a 4-word line for a wrapping burst.
    function automatic logic [1:0] wrap_index(input logic [1:0] start,
                                              input logic [1:0] beat);
        return start + beat;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive enabled cycles and flags expiry on the
// TIMEOUT-th one, so the owner can abandon the bus cycle at that edge.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    assign expired = en && (count_reg == CW'(TIMEOUT - 1));

    always_comb begin
        count_next = count_reg;
        if (clr || expired) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/wb_line_fill_master.sv
// Wishbone master that turns client requests into 4-beat wrapping line reads
// or single-word writes, with a stall timeout per bus cycle.
module wb_line_fill_master
    import wb_defs_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_sel_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic [1:0]  rsp_index_o,
    output logic        rsp_last_o,
    output logic        rsp_err_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i,
    output logic [2:0]  cti_o,
    output logic [1:0]  bte_o
);

    localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

    state_t       state_reg,  state_next;
    logic [31:2]  addr_reg,   addr_next;
    logic [31:0]  wdata_reg,  wdata_next;
    logic [3:0]   sel_reg,    sel_next;
    logic [1:0]   beat_reg,   beat_next;
    logic         rsp_valid_reg, rsp_valid_next;
    rsp_t         rsp_reg,    rsp_next;

    logic         busy;
    logic         ack_ok;
    logic         expired;
    logic [1:0]   cur_index;
    logic         unused_addr_bits;

    assign unused_addr_bits = &{1'b0, req_addr_i[1:0]};

    assign busy      = (state_reg != ST_IDLE);
    // ack_i only counts while a cycle is actually open
    assign ack_ok    = cyc_o && stb_o && ack_i;
    assign cur_index = wrap_index(addr_reg[3:2], beat_reg);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk_i),
        .srst    (rst_i),
        .en      (busy && !ack_i),
        .clr     (!busy || ack_ok),
        .expired (expired)
    );

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        sel_next       = sel_reg;
        beat_next      = beat_reg;
        rsp_valid_next = 1'b0;
        rsp_next       = '0;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_next  = req_addr_i[31:2];
                    wdata_next = req_wdata_i;
                    sel_next   = req_sel_i;
                    beat_next  = '0;
                    state_next = req_write_i ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (ack_ok) begin
                    rsp_valid_next = 1'b1;
                    rsp_next       = '{data: dat_i, index: cur_index,
                                       last: (beat_reg == LAST_BEAT), err: 1'b0};
                    beat_next      = beat_reg + 1'b1;
                    if (beat_reg == LAST_BEAT) begin
                        state_next = ST_IDLE;
                    end
                end else if (expired) begin
                    rsp_valid_next = 1'b1;
                    rsp_next       = '{data: 32'h0, index: cur_index, last: 1'b1, err: 1'b1};
                    state_next     = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (ack_ok || expired) begin
                    rsp_valid_next = 1'b1;
                    rsp_next       = '{data: 32'h0, index: cur_index, last: 1'b1, err: !ack_ok};
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            sel_reg       <= '0;
            beat_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            sel_reg       <= sel_next;
            beat_reg      <= beat_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_reg       <= rsp_next;
        end
    end

    assign req_ready_o = (state_reg == ST_IDLE);

    assign cyc_o = busy;
    assign stb_o = busy;
    assign we_o  = (state_reg == ST_WRITE);
    assign adr_o = busy ? {addr_reg[31:4], cur_index, 2'b00} : 32'h0;

    always_comb begin
        sel_o = 4'h0;
        cti_o = CTI_CLASSIC;
        bte_o = BTE_LINEAR;
        if (state_reg == ST_READ) begin
            sel_o = 4'hF;
            cti_o = (beat_reg == LAST_BEAT) ? CTI_EOB : CTI_INCR;
            bte_o = BTE_WRAP4;
        end else if (state_reg == ST_WRITE) begin
            sel_o = sel_reg;
            cti_o = CTI_EOB;
        end
    end

    // Write data lanes are forced to zero whenever no write cycle is open.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dat_lane
            assign dat_o[8*gi +: 8] = we_o ? wdata_reg[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_data_o  = rsp_reg.data;
    assign rsp_index_o = rsp_reg.index;
    assign rsp_last_o  = rsp_reg.last;
    assign rsp_err_o   = rsp_reg.err;

endmodule
